// File: rtl/tanh_table_fetch_if.sv
// Handshake bundle between the operand source, tanh_table_fetch and the
// interpolation calculator. The master view belongs to whoever feeds
// operands and consumes bundles; the slave view belongs to the fetch block.
`timescale 1ns/1ps

interface tanh_table_fetch_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_z;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] z_value;
    logic signed [31:0] base;
    logic signed [31:0] next_data;
    logic signed [31:0] addr;
    logic        [23:0] remaining;
    logic               neg;

    modport master (
        output in_valid, in_z, out_ready,
        input  in_ready, out_valid, z_value, base, next_data, addr, remaining, neg
    );

    modport slave (
        input  in_valid, in_z, out_ready,
        output in_ready, out_valid, z_value, base, next_data, addr, remaining, neg
    );
endinterface

// File: rtl/tanh_table_fetch.sv
// tanh_table_fetch: folds a Q4.28 operand to |z| (tanh is odd), fetches
// tanh(k) and tanh(k+1) from a small synchronous ROM and hands the
// interpolation bundle to the calculator over valid/ready.
`timescale 1ns/1ps

module tanh_table_fetch #(
    parameter int FRAC_BITS   = 28,
    parameter int TABLE_DEPTH = 9
) (
    input  logic            clk,
    input  logic            rst,
    tanh_table_fetch_if.slave bus
);

    localparam int ADDR_W   = $clog2(TABLE_DEPTH);
    localparam int INT_BITS = 31 - FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BASE = 2'd1,
        RD_NEXT = 2'd2,
        VALID   = 2'd3
    } state_t;

    // round(tanh(k) * 2^28). Entry 1 rounds up from ...5A.8A to ...5B.
    function automatic logic [31:0] rom_word(input int idx);
        logic [31:0] word;
        case (idx)
            0:       word = 32'h0000_0000;
            1:       word = 32'h0C2F_7D5B;
            2:       word = 32'h0F6C_A82F;
            3:       word = 32'h0FEB_BE89;
            4:       word = 32'h0FFD_40B8;
            5:       word = 32'h0FFF_A0CB;
            6:       word = 32'h0FFF_F31D;
            7:       word = 32'h0FFF_FE42;
            8:       word = 32'h0FFF_FFC4;
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    state_t               state_reg;
    state_t               state_next;
    logic signed [31:0]   z_reg;
    logic                 neg_reg;
    logic signed [31:0]   base_reg;
    logic signed [31:0]   next_data_reg;
    logic        [31:0]   rom_data_reg;

    logic        [31:0]   rom [TABLE_DEPTH];
    logic [ADDR_W-1:0]    rom_addr;
    logic signed [31:0]   abs_z;
    logic [INT_BITS-1:0]  k_in;
    logic [INT_BITS-1:0]  k_reg;
    logic                 in_ready;
    logic                 out_valid;
    logic                 accept;
    logic                 load_base;
    logic                 load_next;

    generate
        for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_rom
            assign rom[gi] = rom_word(gi);
        end
    endgenerate

    // Fold to |z|; the most negative code has no positive twin, so it saturates.
    always_comb begin
        if (bus.in_z == 32'sh8000_0000) begin
            abs_z = 32'sh7FFF_FFFF;
        end else if (bus.in_z[31]) begin
            abs_z = -bus.in_z;
        end else begin
            abs_z = bus.in_z;
        end
    end

    assign k_in  = abs_z[30:FRAC_BITS];
    assign k_reg = z_reg[30:FRAC_BITS];

    // Next-state and control decode; ROM address is k while idle, k+1 afterwards.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        load_base  = 1'b0;
        load_next  = 1'b0;
        rom_addr   = ADDR_W'(k_reg) + ADDR_W'(1);
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                rom_addr = ADDR_W'(k_in);
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = RD_BASE;
                end
            end
            RD_BASE: begin
                load_base  = 1'b1;
                state_next = RD_NEXT;
            end
            RD_NEXT: begin
                load_next  = 1'b1;
                state_next = VALID;
            end
            VALID: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand and table-sample registers feeding the output bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_reg         <= '0;
            neg_reg       <= 1'b0;
            base_reg      <= '0;
            next_data_reg <= '0;
        end else begin
            if (accept) begin
                z_reg   <= abs_z;
                neg_reg <= bus.in_z[31];
            end
            if (load_base) begin
                base_reg <= rom_data_reg;
            end
            if (load_next) begin
                next_data_reg <= rom_data_reg;
            end
        end
    end

    // Registered ROM read, no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        rom_data_reg <= rom[rom_addr];
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.z_value   = z_reg;
    assign bus.base      = base_reg;
    assign bus.next_data = next_data_reg;
    assign bus.addr      = {1'b0, k_reg, {FRAC_BITS{1'b0}}};
    assign bus.remaining = z_reg[FRAC_BITS-1 -: 24];
    assign bus.neg       = neg_reg;

endmodule

// File: tb/tb_tanh_table_fetch.sv
// Bench for tanh_table_fetch: directed operands, expected bundles queued
// at issue time and checked by an independent monitor.
`timescale 1ns/1ps

module tb_tanh_table_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tanh_table_fetch_if ifc();

    tanh_table_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // round(tanh(k) * 2^28), hand computed
    localparam logic [31:0] R [9] = '{
        32'h0000_0000, 32'h0C2F_7D5B, 32'h0F6C_A82F, 32'h0FEB_BE89, 32'h0FFD_40B8,
        32'h0FFF_A0CB, 32'h0FFF_F31D, 32'h0FFF_FE42, 32'h0FFF_FFC4
    };

    typedef struct {
        logic [31:0] z;
        logic [31:0] base;
        logic [31:0] nxt;
        logic [31:0] addr;
        logic [23:0] rem;
        logic        neg;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   stream_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] z, input logic [31:0] b, input logic [31:0] n,
                                input logic [31:0] a, input logic [23:0] r, input logic ng);
        exp_t e;
        e.z = z; e.base = b; e.nxt = n; e.addr = a; e.rem = r; e.neg = ng; e.acc_cyc = 0;
        return e;
    endfunction

    // Present an operand at a negedge and wait (bounded) for it to be taken.
    task automatic send(input logic [31:0] z, input exp_t e);
        int waited = 0;
        ifc.in_valid = 1'b1;
        ifc.in_z     = z;
        while (!ifc.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ifc.in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.acc_cyc = cyc;
            sb.push_back(e);
            if (stream_mode && last_acc >= 0) chk("stream_gap", 32'(cyc - last_acc), 32'd4);
            last_acc = cyc;
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: sample late in the low phase, compare against queue head.
    initial begin : monitor
        exp_t e;
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                seen = 1'b0;
            end else if (ifc.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb[0];
                    chk("z_value",   ifc.z_value,          e.z);
                    chk("base",      ifc.base,             e.base);
                    chk("next_data", ifc.next_data,        e.nxt);
                    chk("addr",      ifc.addr,             e.addr);
                    chk("remaining", 32'(ifc.remaining),   32'(e.rem));
                    chk("neg",       32'(ifc.neg),         32'(e.neg));
                    chk("in_ready_busy", 32'(ifc.in_ready), 32'd0);
                    if (!seen) chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
                    seen = 1'b1;
                    if (ifc.out_ready) begin
                        $display("txn z=%h base=%h next=%h addr=%h rem=%h neg=%0d",
                                 ifc.z_value, ifc.base, ifc.next_data, ifc.addr, ifc.remaining, ifc.neg);
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(ifc.in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, "_z_value"},   ifc.z_value,        32'd0);
        chk({tag, "_base"},      ifc.base,           32'd0);
        chk({tag, "_next_data"}, ifc.next_data,      32'd0);
        chk({tag, "_addr"},      ifc.addr,           32'd0);
        chk({tag, "_remaining"}, 32'(ifc.remaining), 32'd0);
        chk({tag, "_neg"},       32'(ifc.neg),       32'd0);
    endtask

    initial begin : stim
        int hs;
        ifc.in_valid  = 1'b0;
        ifc.in_z      = '0;
        ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single operands with out_ready held high
        ifc.out_ready = 1'b1;
        send(32'h1800_0000, mk(32'h1800_0000, R[1], R[2], 32'h1000_0000, 24'h80_0000, 1'b0));
        drain();
        send(32'hE800_0000, mk(32'h1800_0000, R[1], R[2], 32'h1000_0000, 24'h80_0000, 1'b1));
        drain();
        send(32'h8000_0000, mk(32'h7FFF_FFFF, R[7], R[8], 32'h7000_0000, 24'hFF_FFFF, 1'b1));
        drain();
        send(32'h0000_0000, mk(32'h0000_0000, R[0], R[1], 32'h0000_0000, 24'h00_0000, 1'b0));
        drain();

        // Back-pressure: bundle held for 5 cycles with a new operand waiting
        ifc.out_ready = 1'b0;
        send(32'h2C00_0000, mk(32'h2C00_0000, R[2], R[3], 32'h2000_0000, 24'hC0_0000, 1'b0));
        for (int i = 0; i < 20 && !ifc.out_valid; i++) @(negedge clk);
        chk("bp_valid_seen", 32'(ifc.out_valid), 32'd1);
        ifc.in_valid = 1'b1;
        ifc.in_z     = 32'h3A00_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
            chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        end
        ifc.out_ready = 1'b1;
        hs = cyc;
        send(32'h3A00_0000, mk(32'h3A00_0000, R[3], R[4], 32'h3000_0000, 24'hA0_0000, 1'b0));
        chk("bp_accept_gap", 32'(last_acc - hs), 32'd1);
        drain();

        // Streaming: 0.25, 3.0, -7.5, 5.999 back to back
        stream_mode = 1'b1;
        last_acc    = -1;
        send(32'h0400_0000, mk(32'h0400_0000, R[0], R[1], 32'h0000_0000, 24'h40_0000, 1'b0));
        send(32'h3000_0000, mk(32'h3000_0000, R[3], R[4], 32'h3000_0000, 24'h00_0000, 1'b0));
        send(32'h8800_0000, mk(32'h7800_0000, R[7], R[8], 32'h7000_0000, 24'h80_0000, 1'b1));
        send(32'h5FFB_E76C, mk(32'h5FFB_E76C, R[5], R[6], 32'h5000_0000, 24'hFF_BE76, 1'b0));
        stream_mode = 1'b0;
        drain();

        // Reset during RD_NEXT aborts the transaction
        ifc.in_valid = 1'b1;
        ifc.in_z     = 32'h1800_0000;
        chk("abort_idle_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_abort_no_valid", 32'(ifc.out_valid), 32'd0);
        end
        chk("post_abort_queue", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
